branch_resolve_unit: RTL and testbench

- Parametrised successor to the three-stage Power ISA branch unit.
- Resolves b, bc, bclr, bcctr (and optionally bctar) in a valid/ready three-stage pipeline.
- Owns the architectural LR, CTR and TAR, decodes the full BO field, and squashes its own wrong-path entries.
- Sits after decode/issue. Drives the fetch redirect and the pipeline flush.

---
 rtl/branch_resolve_unit_if.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Issue-side bundle between decode/issue and branch_resolve_unit.
// master: the issuer drives the instruction fields and valid_i and observes ready_o.
// slave : the branch unit consumes the fields and drives ready_o.
// Signals:
//   valid_i / ready_o      : handshake; transfer when both are high on a clock edge
//   functionalUnitCode_i   : unit code; the instruction is ignored unless it matches
//   opCode_i, xOpCode_i    : primary and extended opcode
//   BO_i, BI_i             : branch options; CR bit select
//   imm_i                  : LI (b) or BD (bc, low 14 bits) displacement in words
//   AA_i, LK_i, is64Bit_i  : absolute addressing, link, 64-bit mode
//   instructionAddress_i   : CIA of the instruction
//   condReg_i              : CR snapshot, IBM bit numbering 32..63
// ADDR_WIDTH and IMM_WIDTH must match the parameters of the attached unit.
interface branch_resolve_unit_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned IMM_WIDTH  = 24
);
   logic                  valid_i;
   logic                  ready_o;
   logic [2:0]            functionalUnitCode_i;
   logic [5:0]            opCode_i;
   logic [9:0]            xOpCode_i;
   logic [4:0]            BO_i;
   logic [4:0]            BI_i;
   logic [IMM_WIDTH-1:0]  imm_i;
   logic                  AA_i;
   logic                  LK_i;
   logic                  is64Bit_i;
   logic [ADDR_WIDTH-1:0] instructionAddress_i;
   logic [32:63]          condReg_i;

   modport master (
      output valid_i, functionalUnitCode_i, opCode_i, xOpCode_i, BO_i, BI_i,
             imm_i, AA_i, LK_i, is64Bit_i, instructionAddress_i, condReg_i,
      input  ready_o
   );

   modport slave (
      input  valid_i, functionalUnitCode_i, opCode_i, xOpCode_i, BO_i, BI_i,
             imm_i, AA_i, LK_i, is64Bit_i, instructionAddress_i, condReg_i,
      output ready_o
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Three-stage Power ISA branch resolution unit (b, bc, bclr, bcctr, optional bctar).
// S1 decode/target, S2 condition, S3 commit. Owns the architectural LR, CTR (and TAR)
// and squashes its own younger entries when a branch redirects fetch.
// Optional feature: define BRANCH_UNIT_TAR_EN to add the TAR register and bctar (xOpCode 560).
// Ports:
//   clock_i, reset_i       : clock; synchronous active-high reset
//   stall_i                : freezes every stage, blocks issue and SPR writes
//   iss (slave)            : issue bundle, see branch_resolve_unit_if
//   sprWe_i/sprSel_i/sprData_i : SPR write (0=LR, 1=CTR, 2=TAR), only taken when idle
//   redirect_o/redirectPC_o    : one-cycle flush+redirect pulse and next PC
//   done_o/taken_o/illegal_o   : retire pulse and its qualifiers
//   linkReg_o/countReg_o       : architectural LR and CTR
// ADDR_WIDTH must exceed 32 and IMM_WIDTH+2 must not exceed ADDR_WIDTH.
module branch_resolve_unit #(
   parameter int unsigned          ADDR_WIDTH       = 64,
   parameter int unsigned          IMM_WIDTH        = 24,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = '0,
   parameter logic [2:0]           BRANCH_UNIT_CODE = 3'd3
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  stall_i,
   branch_resolve_unit_if.slave  iss,
   input  logic                  sprWe_i,
   input  logic [1:0]            sprSel_i,
   input  logic [ADDR_WIDTH-1:0] sprData_i,
   output logic                  redirect_o,
   output logic [ADDR_WIDTH-1:0] redirectPC_o,
   output logic                  done_o,
   output logic                  taken_o,
   output logic                  illegal_o,
   output logic [ADDR_WIDTH-1:0] linkReg_o,
   output logic [ADDR_WIDTH-1:0] countReg_o
);

   localparam int unsigned LI_EXT = ADDR_WIDTH - IMM_WIDTH - 2;
   localparam int unsigned BD_EXT = ADDR_WIDTH - 16;
   localparam logic [ADDR_WIDTH-1:0] LOW32_MASK = {{(ADDR_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};

   // internal branch kinds
   localparam logic [2:0] K_B     = 3'd0;
   localparam logic [2:0] K_BC    = 3'd1;
   localparam logic [2:0] K_BCLR  = 3'd2;
   localparam logic [2:0] K_BCCTR = 3'd3;
   localparam logic [2:0] K_BCTAR = 3'd4;

   // BO is kept as bits [4:1] in little-endian order: [4]=BO0, [3]=BO1, [2]=BO2, [1]=BO3
   typedef struct packed {
      logic [2:0]            kind;
      logic [4:1]            bo;
      logic                  cr_bit;
      logic [IMM_WIDTH-1:0]  imm;
      logic                  aa;
      logic                  lk;
      logic                  is64;
      logic [ADDR_WIDTH-1:0] cia;
   } s1_t;

   typedef struct packed {
      logic [2:0]            kind;
      logic [4:1]            bo;
      logic                  cr_bit;
      logic                  lk;
      logic                  is64;
      logic [ADDR_WIDTH-1:0] cia;
      logic [ADDR_WIDTH-1:0] target;
   } s2_t;

   typedef struct packed {
      logic                  taken;
      logic                  illegal;
      logic                  dec_ctr;
      logic                  lk;
      logic                  is64;
      logic [ADDR_WIDTH-1:0] cia;
      logic [ADDR_WIDTH-1:0] target;
   } s3_t;

   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s3_valid_q, s3_valid_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   s3_t  s3_q, s3_d;

   logic [ADDR_WIDTH-1:0] lr_q, lr_d;
   logic [ADDR_WIDTH-1:0] ctr_q, ctr_d;
`ifdef BRANCH_UNIT_TAR_EN
   logic [ADDR_WIDTH-1:0] tar_q, tar_d;
`endif

   logic                  redirect_q, redirect_d;
   logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic                  done_q, done_d;
   logic                  taken_q, taken_d;
   logic                  illegal_q, illegal_d;

   logic       dec_known;
   logic [2:0] dec_kind;
   logic       rd_lr;
   logic       rd_ctr;
   logic       hazard;
   logic       ready_c;
   logic       accept;
   logic       unused_bo_hint;

   // BO4 is a prediction hint with no architectural effect
   assign unused_bo_hint = iss.BO_i[0];

   // Decode of the offered instruction and the SPRs it reads
   always_comb begin
      dec_known = 1'b0;
      dec_kind  = K_B;
      if (iss.functionalUnitCode_i == BRANCH_UNIT_CODE) begin
         case (iss.opCode_i)
            6'd18: begin dec_known = 1'b1; dec_kind = K_B;  end
            6'd16: begin dec_known = 1'b1; dec_kind = K_BC; end
            6'd19: begin
               case (iss.xOpCode_i)
                  10'd16:  begin dec_known = 1'b1; dec_kind = K_BCLR;  end
                  10'd528: begin dec_known = 1'b1; dec_kind = K_BCCTR; end
`ifdef BRANCH_UNIT_TAR_EN
                  10'd560: begin dec_known = 1'b1; dec_kind = K_BCTAR; end
`endif
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
      rd_lr  = dec_known & (dec_kind == K_BCLR);
      rd_ctr = dec_known & ((dec_kind == K_BCCTR) | ((dec_kind != K_B) & ~iss.BO_i[2]));
   end

   // Interlock: an LR/CTR writer in S1 or S2 would commit after the reader samples it
   always_comb begin
      hazard = (rd_lr  & ((s1_valid_q & s1_q.lk) | (s2_valid_q & s2_q.lk))) |
               (rd_ctr & ((s1_valid_q & (s1_q.kind != K_B) & ~s1_q.bo[2]) |
                          (s2_valid_q & (s2_q.kind != K_B) & ~s2_q.bo[2])));
   end

   assign ready_c     = ~reset_i & ~stall_i & ~hazard;
   assign iss.ready_o = ready_c;
   assign accept      = iss.valid_i & ready_c;

   // S1 -> S2: target generation
   logic [ADDR_WIDTH-1:0] li_ext, bd_ext, base, tgt;
   always_comb begin
      li_ext = {{LI_EXT{s1_q.imm[IMM_WIDTH-1]}}, s1_q.imm, 2'b00};
      bd_ext = {{BD_EXT{s1_q.imm[13]}}, s1_q.imm[13:0], 2'b00};
      base   = s1_q.aa ? '0 : s1_q.cia;
      case (s1_q.kind)
         K_B:     tgt = li_ext + base;
         K_BC:    tgt = bd_ext + base;
         K_BCLR:  tgt = {lr_q[ADDR_WIDTH-1:2], 2'b00};
         K_BCCTR: tgt = {ctr_q[ADDR_WIDTH-1:2], 2'b00};
`ifdef BRANCH_UNIT_TAR_EN
         K_BCTAR: tgt = {tar_q[ADDR_WIDTH-1:2], 2'b00};
`endif
         default: tgt = '0;
      endcase
   end

   // S2 -> S3: condition evaluation
   logic [ADDR_WIDTH-1:0] ctr_m1;
   logic ctr_nz, ctr_ok, cond_ok, is_illegal, uses_bo;
   always_comb begin
      ctr_m1     = ctr_q - ADDR_WIDTH'(1);
      ctr_nz     = s2_q.is64 ? (ctr_m1 != '0) : (ctr_m1[31:0] != 32'd0);
      ctr_ok     = s2_q.bo[2] | (ctr_nz ^ s2_q.bo[1]);
      cond_ok    = s2_q.bo[4] | (s2_q.cr_bit == s2_q.bo[3]);
      uses_bo    = (s2_q.kind != K_B);
      is_illegal = (s2_q.kind == K_BCCTR) & ~s2_q.bo[2];
   end

   // S3: next instruction address, upper word cleared in 32-bit mode
   logic [ADDR_WIDTH-1:0] next_pc;
   always_comb begin
      next_pc = s3_q.taken ? s3_q.target : (s3_q.cia + ADDR_WIDTH'(4));
      if (!s3_q.is64) next_pc = next_pc & LOW32_MASK;
   end

   // Next-state: pipeline advance, commit, SPR write
   logic commit_flush;
   always_comb begin
      s1_valid_d    = s1_valid_q;
      s2_valid_d    = s2_valid_q;
      s3_valid_d    = s3_valid_q;
      s1_d          = s1_q;
      s2_d          = s2_q;
      s3_d          = s3_q;
      lr_d          = lr_q;
      ctr_d         = ctr_q;
`ifdef BRANCH_UNIT_TAR_EN
      tar_d         = tar_q;
`endif
      redirect_d    = 1'b0;
      done_d        = 1'b0;
      taken_d       = taken_q;
      illegal_d     = illegal_q;
      redirect_pc_d = redirect_pc_q;
      commit_flush  = 1'b0;

      if (!stall_i) begin
         if (s3_valid_q) begin
            done_d    = 1'b1;
            taken_d   = s3_q.taken;
            illegal_d = s3_q.illegal;
            if (!s3_q.illegal) begin
               redirect_d    = 1'b1;
               redirect_pc_d = next_pc;
               commit_flush  = 1'b1;
               if (s3_q.dec_ctr) ctr_d = ctr_q - ADDR_WIDTH'(1);
               if (s3_q.lk)      lr_d  = s3_q.cia + ADDR_WIDTH'(4);
            end
         end else if (sprWe_i && !s1_valid_q && !s2_valid_q && !iss.valid_i) begin
            case (sprSel_i)
               2'd0: lr_d  = sprData_i;
               2'd1: ctr_d = sprData_i;
`ifdef BRANCH_UNIT_TAR_EN
               2'd2: tar_d = sprData_i;
`endif
               default: ;
            endcase
         end

         // the instruction accepted on the commit edge is already on the redirected path
         s1_valid_d   = accept & dec_known;
         s1_d         = '0;
         s1_d.kind    = dec_kind;
         s1_d.bo      = iss.BO_i[4:1];
         s1_d.cr_bit  = iss.condReg_i[{1'b1, iss.BI_i}];
         s1_d.imm     = iss.imm_i;
         s1_d.aa      = iss.AA_i;
         s1_d.lk      = iss.LK_i;
         s1_d.is64    = iss.is64Bit_i;
         s1_d.cia     = iss.instructionAddress_i;

         s2_valid_d   = s1_valid_q & ~commit_flush;
         s2_d         = '0;
         s2_d.kind    = s1_q.kind;
         s2_d.bo      = s1_q.bo;
         s2_d.cr_bit  = s1_q.cr_bit;
         s2_d.lk      = s1_q.lk;
         s2_d.is64    = s1_q.is64;
         s2_d.cia     = s1_q.cia;
         s2_d.target  = tgt;

         s3_valid_d   = s2_valid_q & ~commit_flush;
         s3_d         = '0;
         s3_d.taken   = ~is_illegal & (uses_bo ? (ctr_ok & cond_ok) : 1'b1);
         s3_d.illegal = is_illegal;
         s3_d.dec_ctr = uses_bo & ~s2_q.bo[2] & ~is_illegal;
         s3_d.lk      = s2_q.lk;
         s3_d.is64    = s2_q.is64;
         s3_d.cia     = s2_q.cia;
         s3_d.target  = s2_q.target;
      end
   end

   // State registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         s1_valid_q    <= 1'b0;
         s2_valid_q    <= 1'b0;
         s3_valid_q    <= 1'b0;
         s1_q          <= '0;
         s2_q          <= '0;
         s3_q          <= '0;
         lr_q          <= '0;
         ctr_q         <= '0;
`ifdef BRANCH_UNIT_TAR_EN
         tar_q         <= '0;
`endif
         redirect_q    <= 1'b0;
         redirect_pc_q <= RESET_VECTOR;
         done_q        <= 1'b0;
         taken_q       <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s2_valid_q    <= s2_valid_d;
         s3_valid_q    <= s3_valid_d;
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         s3_q          <= s3_d;
         lr_q          <= lr_d;
         ctr_q         <= ctr_d;
`ifdef BRANCH_UNIT_TAR_EN
         tar_q         <= tar_d;
`endif
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         done_q        <= done_d;
         taken_q       <= taken_d;
         illegal_q     <= illegal_d;
      end
   end

   assign redirect_o   = redirect_q;
   assign redirectPC_o = redirect_pc_q;
   assign done_o       = done_q;
   assign taken_o      = taken_q;
   assign illegal_o    = illegal_q;
   assign linkReg_o    = lr_q;
   assign countReg_o   = ctr_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push their expected
// retirement into a queue; a monitor pops and compares on every done/redirect pulse.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        spr_we;
   logic [1:0]  spr_sel;
   logic [63:0] spr_data;
   logic        redirect, done, taken, illegal;
   logic [63:0] rpc, lr, ctr;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.ADDR_WIDTH(64), .IMM_WIDTH(24)) iss ();

   branch_resolve_unit #(
      .ADDR_WIDTH(64), .IMM_WIDTH(24), .RESET_VECTOR(64'h0), .BRANCH_UNIT_CODE(3'd3)
   ) dut (
      .clock_i(clk), .reset_i(rst), .stall_i(stall), .iss(iss),
      .sprWe_i(spr_we), .sprSel_i(spr_sel), .sprData_i(spr_data),
      .redirect_o(redirect), .redirectPC_o(rpc), .done_o(done), .taken_o(taken),
      .illegal_o(illegal), .linkReg_o(lr), .countReg_o(ctr)
   );

   typedef struct {
      logic        redirect;
      logic        taken;
      logic        illegal;
      logic [63:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   w;

   function automatic exp_t mk(input logic r, input logic t, input logic i, input logic [63:0] pc);
      exp_t e;
      e.redirect = r; e.taken = t; e.illegal = i; e.pc = pc;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Offer one instruction from a negedge; returns on the negedge after acceptance
   task automatic offer(input logic [2:0] fu, input logic [5:0] op, input logic [9:0] xop,
                        input logic [4:0] bo, input logic [23:0] imm, input logic lk,
                        input logic is64, input logic [63:0] cia, input logic push,
                        input exp_t e, output int waits);
      iss.functionalUnitCode_i = fu;
      iss.opCode_i             = op;
      iss.xOpCode_i            = xop;
      iss.BO_i                 = bo;
      iss.BI_i                 = 5'd0;
      iss.imm_i                = imm;
      iss.AA_i                 = 1'b0;
      iss.LK_i                 = lk;
      iss.is64Bit_i            = is64;
      iss.instructionAddress_i = cia;
      iss.valid_i              = 1'b1;
      waits = 0;
      #1;
      while (!iss.ready_o && waits < 20) begin
         @(negedge clk); #1;
         waits++;
      end
      if (!iss.ready_o) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles at cia 0x%0h", waits, cia);
      end else if (push) begin
         exp_q.push_back(e);
      end
      @(negedge clk);
      iss.valid_i = 1'b0;
   endtask

   task automatic spr_write(input logic [1:0] sel, input logic [63:0] data);
      spr_we = 1'b1; spr_sel = sel; spr_data = data;
      @(negedge clk);
      spr_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e0;
      e0 = mk(1'b0, 1'b0, 1'b0, 64'h0);
      rst = 1'b1; stall = 1'b0; spr_we = 1'b0; spr_sel = 2'd0; spr_data = 64'h0;
      iss.valid_i = 1'b0; iss.functionalUnitCode_i = 3'd0; iss.opCode_i = 6'd0;
      iss.xOpCode_i = 10'd0; iss.BO_i = 5'd0; iss.BI_i = 5'd0; iss.imm_i = 24'd0;
      iss.AA_i = 1'b0; iss.LK_i = 1'b0; iss.is64Bit_i = 1'b1;
      iss.instructionAddress_i = 64'h0; iss.condReg_i = '0;

      // retirement monitor
      fork
         forever begin
            @(negedge clk);
            if (!rst && (done || redirect)) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_retire: done=%0b redirect=%0b pc=0x%0h", done, redirect, rpc);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (done !== 1'b1 || redirect !== e.redirect || taken !== e.taken ||
                      illegal !== e.illegal || (e.redirect && rpc !== e.pc)) begin
                     n_fail++;
                     $display("FAIL retire: got done=%0b redirect=%0b taken=%0b illegal=%0b pc=0x%0h expected done=1 redirect=%0b taken=%0b illegal=%0b pc=0x%0h",
                              done, redirect, taken, illegal, rpc, e.redirect, e.taken, e.illegal, e.pc);
                  end
               end
            end
         end
      join_none

      idle(2);
      rst = 1'b0;
      idle(3);
      check("reset_pc", rpc, 64'h0);
      check("reset_redirect", redirect, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ready", iss.ready_o, 1'b1);
      check("reset_lr", lr, 64'h0);
      check("reset_ctr", ctr, 64'h0);

      // bl at 0x1000, LI=4: three-cycle latency
      offer(3'd3, 6'd18, 10'd0, 5'd0, 24'd4, 1'b1, 1'b1, 64'h1000, 1'b1, mk(1, 1, 0, 64'h1010), w);
      check("bl_lat1", done, 1'b0);
      @(negedge clk); check("bl_lat2", done, 1'b0);
      @(negedge clk); check("bl_lat3", done, 1'b0);
      @(negedge clk); check("bl_lat_done", done, 1'b1);
      idle(2);
      check("bl_lr", lr, 64'h1004);

      // bdnz twice with CTR=2
      spr_write(2'd1, 64'd2);
      offer(3'd3, 6'd16, 10'd0, 5'd16, 24'hFFFFFE, 1'b0, 1'b1, 64'h2000, 1'b1, mk(1, 1, 0, 64'h1FF8), w);
      idle(5);
      check("bdnz1_ctr", ctr, 64'd1);
      offer(3'd3, 6'd16, 10'd0, 5'd16, 24'hFFFFFE, 1'b0, 1'b1, 64'h2000, 1'b1, mk(1, 0, 0, 64'h2004), w);
      idle(5);
      check("bdnz2_ctr", ctr, 64'd0);

      // 32-bit bdz: only the low CTR word is tested, upper PC word cleared
      spr_write(2'd1, 64'h1_0000_0001);
      offer(3'd3, 6'd16, 10'd0, 5'd18, 24'h40, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 1'b1,
            mk(1, 1, 0, 64'h100), w);
      idle(5);
      check("bdz32_ctr", ctr, 64'h1_0000_0000);

      // bcctr with decrementing BO is illegal
      offer(3'd3, 6'd19, 10'd528, 5'd0, 24'd0, 1'b0, 1'b1, 64'h2100, 1'b1, mk(0, 0, 1, 64'h0), w);
      idle(5);
      check("bcctr_ill_ctr", ctr, 64'h1_0000_0000);
      check("bcctr_ill_pc_held", rpc, 64'h100);

      // bl then dependent bclr
      offer(3'd3, 6'd18, 10'd0, 5'd0, 24'h10, 1'b1, 1'b1, 64'h3000, 1'b1, mk(1, 1, 0, 64'h3040), w);
      offer(3'd3, 6'd19, 10'd16, 5'd20, 24'd0, 1'b0, 1'b1, 64'h3040, 1'b1, mk(1, 1, 0, 64'h3004), w);
      check("bclr_interlock_cycles", 64'(w), 64'd2);
      idle(5);
      check("bclr_lr", lr, 64'h3004);

      // taken b squashes two back-to-back bc; SPR write while busy is dropped
      offer(3'd3, 6'd18, 10'd0, 5'd0, 24'd8, 1'b0, 1'b1, 64'h4000, 1'b1, mk(1, 1, 0, 64'h4020), w);
      offer(3'd3, 6'd16, 10'd0, 5'd20, 24'd1, 1'b0, 1'b1, 64'h4004, 1'b0, e0, w);
      offer(3'd3, 6'd16, 10'd0, 5'd20, 24'd1, 1'b0, 1'b1, 64'h4008, 1'b0, e0, w);
      spr_write(2'd1, 64'h55);
      idle(6);
      check("squash_drain", 64'(exp_q.size()), 64'd0);
      check("busy_spr_ignored", ctr, 64'h1_0000_0000);

      // stall for 5 cycles with a b in S2
      offer(3'd3, 6'd18, 10'd0, 5'd0, 24'hFFFFFF, 1'b0, 1'b1, 64'h5000, 1'b1, mk(1, 1, 0, 64'h4FFC), w);
      @(negedge clk);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_done", done, 1'b0);
         check("stall_redirect", redirect, 1'b0);
      end
      check("stall_ready", iss.ready_o, 1'b0);
      check("stall_pc_held", rpc, 64'h4020);
      stall = 1'b0;
      idle(6);
      check("stall_drain", 64'(exp_q.size()), 64'd0);

      // dropped: unknown xOpCode, unknown opcode, foreign unit code
      offer(3'd3, 6'd19, 10'd33, 5'd20, 24'd0, 1'b0, 1'b1, 64'h5100, 1'b0, e0, w);
      offer(3'd3, 6'd31, 10'd0, 5'd20, 24'd0, 1'b0, 1'b1, 64'h5104, 1'b0, e0, w);
      offer(3'd2, 6'd18, 10'd0, 5'd0, 24'd4, 1'b1, 1'b1, 64'h5108, 1'b0, e0, w);
      idle(5);
      check("dropped_lr", lr, 64'h3004);

      // reset with a bl in flight
      offer(3'd3, 6'd18, 10'd0, 5'd0, 24'd4, 1'b1, 1'b1, 64'h6000, 1'b0, e0, w);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(5);
      check("midreset_pc", rpc, 64'h0);
      check("midreset_lr", lr, 64'h0);
      check("midreset_ctr", ctr, 64'h0);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
